// File: rtl/fifo2_pkg.sv
// Shared defaults and read-controller state encoding for the FIFO2 cell array.
package fifo2_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_PTR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } rd_state_t;

endpackage

// File: rtl/fifo_sel_decode.sv
// Cell index to one-hot select decoder, shared by the read and write controllers.
module fifo_sel_decode #(
  parameter int PTR_W = 3,
  parameter int DEPTH = 8
) (
  input  logic [PTR_W-1:0] idx,
  output logic [DEPTH-1:0] onehot
);

  assign onehot = {{(DEPTH-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the FIFO2 cell array: selects a cell, captures its
// bus word, and holds it on a valid/ready handshake. The writer has priority.
module fifo_read_ctrl
  import fifo2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [PTR_W:0]     wr_ptr,
  input  logic               wr_req,
  input  logic [WIDTH-1:0]   bus_data,
  output logic [DEPTH-1:0]   rd_sel,
  output logic [PTR_W:0]     rd_ptr,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               empty,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic             can_fetch;
  logic             fetch_go;
  logic             drop_valid;
  logic [DEPTH-1:0] sel_dec;

  assign empty     = (rd_ptr == wr_ptr);
  assign count     = wr_ptr - rd_ptr;
  // A fetch decided now drives rd_sel next cycle, which is the cycle wr_req claims.
  assign can_fetch = !empty && !wr_req;

  fifo_sel_decode #(
    .PTR_W (PTR_W),
    .DEPTH (DEPTH)
  ) u_sel_decode (
    .idx    (rd_ptr[PTR_W-1:0]),
    .onehot (sel_dec)
  );

  always_comb begin
    state_nxt  = state;
    fetch_go   = 1'b0;
    drop_valid = 1'b0;
    case (state)
      IDLE: begin
        if (can_fetch) begin
          state_nxt = FETCH;
          fetch_go  = 1'b1;
        end
      end
      FETCH: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (can_fetch) begin
            state_nxt = FETCH;
            fetch_go  = 1'b1;
          end else begin
            state_nxt  = IDLE;
            drop_valid = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      rd_sel    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_sel <= fetch_go ? sel_dec : '0;
      // The selected cell's word is on the bus for the whole FETCH cycle.
      if (state == FETCH) begin
        out_data  <= bus_data;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + PTR_ONE;
      end else if (drop_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

  a_sel_onehot0: assert property (@(posedge clk) disable iff (clear) $onehot0(rd_sel))
    else $error("rd_sel multi-hot: %b", rd_sel);

  a_sel_in_fetch: assert property (@(posedge clk) disable iff (clear) (rd_sel != '0) |-> (state == FETCH))
    else $error("rd_sel nonzero outside FETCH: %b", rd_sel);

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller for the FIFO2 memory-cell array: the mirror of the write path.
- Tracks the read pointer against the writer's pointer.
- Drives one-hot cell selects with write-enable held off, so the addressed cell places its word on the shared tri-state bus.
- Captures that word into an output register and presents it downstream on a valid/ready handshake.
- Sits between the cell array and the FIFO consumer.
- Arbitrates array access with the write controller; the writer wins.

Parameters:
WIDTH, 4, data word width (matches cell width)
DEPTH, 8, number of memory cells; power of two
PTR_W, 3, log2(DEPTH); pointers carry one extra wrap bit

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
wr_ptr  in  PTR_W+1  writer's pointer, same clock domain, wrap bit in MSB
wr_req  in  1  high in cycle N means the writer owns the array in cycle N+1
bus_data  in  WIDTH  shared tri-state cell output bus
rd_sel  out  DEPTH  registered one-hot cell select for reads; OR-combined upstream with the writer's select
rd_ptr  out  PTR_W+1  read pointer
out_data  out  WIDTH  captured word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts the word
empty  out  1  rd_ptr == wr_ptr (combinational)
count  out  PTR_W+1  wr_ptr - rd_ptr, modulo 2^(PTR_W+1)

Behaviour:
- Reset, when clear is high at a clk edge:
  - state IDLE, rd_ptr 0, rd_sel 0, out_data 0, out_valid 0.
  - clear overrides every other input.
  - Reset during FETCH: rd_sel drops next cycle, the bus word is discarded and rd_ptr does not advance.
- States: IDLE, FETCH, HOLD. Encoding lives in the package.
- IDLE:
  - rd_sel = 0.
  - If !empty && !wr_req, go to FETCH and load rd_sel = onehot(rd_ptr[PTR_W-1:0]).
  - Otherwise stay in IDLE.
- FETCH: exactly one cycle with rd_sel one-hot. At its closing edge:
  - out_data <= bus_data, out_valid <= 1;
  - rd_ptr <= rd_ptr + 1 (wraps naturally, wrap bit toggles at DEPTH);
  - rd_sel <= 0; go to HOLD.
- HOLD:
  - out_valid = 1; out_data is stable until accepted.
  - out_ready = 0: stay in HOLD.
  - out_ready = 1, the word is accepted. If !empty && !wr_req, go directly to FETCH (back-to-back). Otherwise clear out_valid and go to IDLE.
  - In the back-to-back case out_valid stays 1 through FETCH, carrying the old word; the new word replaces it at FETCH's end.
- Latency: from non-empty with the array free, the first word is valid 2 cycles later. Sustained throughput is 1 word per 2 cycles.
- Arbitration: wr_req wins. If wr_req is high in the deciding cycle, the reader waits and re-evaluates each cycle. The reader never drives rd_sel in a cycle the writer owns.
- empty and count use the current wr_ptr and rd_ptr.
- A word written in cycle N is readable in the decision of cycle N+1 at the earliest, once wr_ptr updates.
- Full/overflow is the writer's responsibility. count == DEPTH is legal. count > DEPTH is a protocol violation, and behaviour is then undefined.
- rd_sel is never multi-hot and is never nonzero outside FETCH. Assertions must cover both.

Decomposition:
- Package fifo2_pkg: WIDTH, DEPTH and PTR_W defaults; state encoding IDLE=2'b00, FETCH=2'b01, HOLD=2'b10.
- One sub-module, fifo_sel_decode: PTR_W-bit index to DEPTH-bit one-hot. Shared with the write controller.

Test Plan:
- Reset then idle: wr_ptr=0 for 10 cycles -> rd_sel=0, out_valid=0, empty=1, count=0 throughout.
- Single word: cell 0 bus=4'hA, wr_ptr 0->1 -> FETCH next cycle with rd_sel=8'b00000001. Then out_data=4'hA, out_valid=1, rd_ptr=1, empty=1.
- Stream with out_ready=1: wr_ptr=8 (full), cells hold 1..8 -> out_data sequence 1..8 at one word per 2 cycles, no gaps. rd_sel walks 0x01..0x80 and rd_ptr ends at 8 (wrap bit set).
- Backpressure: out_ready=0 for 5 cycles with 3 words pending -> out_data frozen, rd_sel=0, rd_ptr unchanged. Releasing out_ready resumes the next word 2 cycles later.
- Arbitration: wr_req=1 while non-empty -> rd_sel stays 0. wr_req falls at cycle N -> rd_sel asserts at N+1.
- Wrap and mid-op reset: rd_ptr=7, wr_ptr=9 -> reads cell 7 then cell 0, rd_ptr=9. Then clear during FETCH -> next cycle rd_ptr=0, out_valid=0, rd_sel=0.
